// File: rtl/hex_scan_mux.sv
// Time-multiplexed hex digit scanner feeding a shared 7-segment decoder.
// New values are double-buffered and swapped in only at frame boundaries.
module hex_scan_mux #(
   parameter int DIGITS    = 4,
   parameter int DIV       = 1000,
   parameter int BLANK_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_data,
   input  logic                  lz_en,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     dig_en,
   output logic                  frame_start
);

   localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = $clog2(DIGITS);

   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   // Each digit slot opens in BLANK, or directly in SHOW when blanking is disabled.
   localparam state_t SLOT_FIRST = (BLANK_CYC > 0) ? BLANK : SHOW;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   active_q, active_d;
   logic [4*DIGITS-1:0]   pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;

   logic                  accept;
   logic                  slot_end;
   logic                  frame_end;
   logic [3:0]            cur_nib;
   logic                  suppress;

   assign load_ready = !pend_vld_q && !rst;
   assign accept     = load_valid && load_ready;
   assign slot_end   = (state_q == SHOW) && (cnt_q == DIV_LAST);
   assign frame_end  = slot_end && (idx_q == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SLOT_FIRST;
         idx_q      <= '0;
         cnt_q      <= '0;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      unique case (state_q)
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = SHOW;
            end
         end
         SHOW: begin
            if (slot_end) begin
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
               state_d = SLOT_FIRST;
            end
         end
         default: state_d = SLOT_FIRST;
      endcase

      // Swap and accept never coincide: accept requires the pending slot empty.
      active_d   = active_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (frame_end && pend_vld_q) begin
         active_d   = pend_q;
         pend_vld_d = 1'b0;
      end
      if (accept) begin
         pend_d     = load_data;
         pend_vld_d = 1'b1;
      end
   end

   always_comb begin
      cur_nib     = active_q[{idx_q, 2'b00} +: 4];
      suppress    = lz_en && (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
      nibble      = '0;
      dig_en      = '0;
      frame_start = 1'b0;
      if (!rst) begin
         frame_start = (state_q == SLOT_FIRST) && (idx_q == '0) && (cnt_q == '0);
         if ((state_q == SHOW) && !suppress) begin
            nibble        = cur_nib;
            dig_en[idx_q] = 1'b1;
         end
      end
   end

endmodule

// File: doc/hex_scan_mux.md
Name: hex_scan_mux

Overview:
- Upstream stage of the 7-segment NAND decoder.
- Time-multiplexes a multi-digit hex value onto one shared 4-bit decoder input and drives one-hot, active-high digit enables.
- Accepts new display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows mixed old and new digits.
- Provides inter-digit blanking against ghosting and optional leading-zero suppression.

Parameters:
- DIGITS, 4, number of digits scanned. Must be ≥2.
- DIV, 1000, clock cycles each digit is shown. Must be ≥1.
- BLANK_CYC, 2, all-off guard cycles before each digit. 0 means no blank phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  new value offered.
- load_ready  out  1  pending slot free; equals !pend_vld. Reads 0 while rst=1.
- load_data  in  4*DIGITS  hex value; nibble i drives digit i (digit 0 = LSN).
- lz_en  in  1  leading-zero suppression enable. Sampled live, no latching.
- nibble  out  4  hex digit to the decoder inputs (in_000 = LSB).
- dig_en  out  DIGITS  one-hot, active-high digit common enable.
- frame_start  out  1  one-cycle pulse on the first cycle of digit 0's slot.

Behaviour:
- Registers:
  - active[4*DIGITS], pend[4*DIGITS], pend_vld.
  - idx: digit index, clog2(DIGITS) bits.
  - cnt: cycle counter, wide enough for max(DIV, BLANK_CYC)-1.
  - state: BLANK or SHOW.
- All outputs are pure combinational decode of registers; there is no added latency.
- Reset (rst=1 at a clock edge):
  - active=0, pend=0, pend_vld=0, idx=0, cnt=0.
  - state=BLANK, or SHOW if BLANK_CYC=0.
  - Outputs during and after reset: dig_en=0, nibble=0, frame_start=1 on the first post-reset cycle.
  - load_valid is ignored while rst=1.
  - Mid-frame reset aborts the scan immediately; the next frame starts from digit 0.
- Handshake:
  - A load is accepted when load_valid & load_ready at a clock edge: pend<=load_data, pend_vld<=1.
  - load_data may change freely when no load is accepted.
- State machine:
  - BLANK: dig_en=0, nibble=0.
    - cnt increments each cycle.
    - At cnt=BLANK_CYC-1: cnt<=0, state<=SHOW.
  - SHOW: nibble=active[idx]; dig_en[idx]=1 unless the digit is suppressed.
    - cnt increments each cycle.
    - At cnt=DIV-1: cnt<=0, idx<=(idx==DIGITS-1)?0:idx+1, state<=BLANK (stays SHOW if BLANK_CYC=0).
- Frame boundary (the SHOW→next transition with idx=DIGITS-1):
  - If pend_vld: active<=pend, pend_vld<=0. load_ready rises on the following cycle.
  - A load cannot be accepted in the same cycle (ready=0 while pending is full).
  - If pend_vld=0 at the boundary, a load accepted that cycle goes to pend and waits for the next boundary.
- Leading-zero suppression:
  - Digit i>0 is suppressed when lz_en=1 and active nibbles i..DIGITS-1 are all 0.
  - When suppressed: dig_en=0 and nibble=0, but slot timing is unchanged.
  - Digit 0 is never suppressed.
- Timing:
  - Frame length is exactly DIGITS*(BLANK_CYC+DIV) cycles.
  - frame_start period equals the frame length.
  - At most one dig_en bit is high in any cycle.
- Load latency: from acceptance to display is at most one full frame plus one cycle.

Test Plan:
(All scenarios use DIGITS=4, DIV=4, BLANK_CYC=1, so frame = 20 cycles, unless noted.)
1. Reset, then run 40 cycles with no load.
   - dig_en is 0 throughout reset.
   - After reset: dig_en pattern per frame is 0000×1, 0001×4, 0000×1, 0010×4, 0000×1, 0100×4, 0000×1, 1000×4.
   - nibble=0 throughout; frame_start pulses at cycles 0 and 20; load_ready=1.
2. Load 16'h1A2F with lz_en=0 mid-frame.
   - load_ready drops the next cycle.
   - The current frame still shows 0s.
   - The next frame shows nibble F,2,A,1 with dig_en 0001,0010,0100,1000.
   - load_ready returns to 1 one cycle after the boundary.
3. Load 16'h0030 with lz_en=1.
   - Digits 2 and 3 have dig_en=0 during their slots; digit1 shows 3, digit0 shows 0.
   - Then load 16'h0000: only dig_en=0001 with nibble 0 appears.
   - With lz_en=0, all four digits show 0.
4. Back-to-back loads: 16'h1111 accepted, then 16'h2222 held with load_valid=1.
   - 16'h2222 stalls with ready=0 until the boundary, is accepted one cycle later, and displays one frame after 16'h1111.
   - No frame mixes 1s and 2s.
5. Assert rst during digit 2's SHOW with a pending load.
   - The pending load is discarded and active returns to 0.
   - The scan restarts at BLANK/digit 0 and frame_start pulses.
6. BLANK_CYC=0, DIV=1.
   - dig_en rotates 0001→0010→0100→1000 every cycle with no all-off cycles.
   - frame_start fires every 4 cycles; a load is displayed within 5 cycles.
